// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if: valid/ready byte-write channel between the formatting core
// (master) and the LCD front-end sequencer (slave).
interface lcd_sequencer_if;
  logic       req_valid;  // master has a byte to write
  logic       req_rs;     // 0 = command, 1 = data
  logic [7:0] req_data;   // byte to write
  logic       req_ready;  // slave accepts the byte at the next rising edge

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: front-end controller for the character-LCD pulse driver.
// Waits out LCD power-up, plays the HD44780 8-bit init sequence, then forwards
// command/data bytes from the core as 1-cycle send strobes, each followed by
// the command-specific execution delay.
// Optional feature: define LCD_AUTOWRAP_EN to track the cursor and insert a
// set-DDRAM-address command when a data write would run past column 16.
module lcd_sequencer #(
  parameter int unsigned PWR_DLY = 750000,  // power-up wait after reset
  parameter int unsigned CMD_DLY = 2500,    // wait after a normal byte
  parameter int unsigned CLR_DLY = 82000,   // wait after clear / return-home
  parameter int unsigned CNT_W   = 20       // holds max(PWR_DLY, CLR_DLY)
) (
  input  logic           clk,
  input  logic           rst,
  lcd_sequencer_if.slave bus,
  output logic           init_done,
  output logic           lcd_send,
  output logic           lcd_rs_sel,
  output logic [7:0]     lcd_cmd_data
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SEND,
    INIT_WAIT,
    IDLE,
    SEND,
    WAIT
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_DLY - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_DLY - 1);

  // Init sequence: function set 8-bit/2-line, display on, entry mode, clear.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Counter load value for the wait that follows a strobed byte.
  function automatic logic [CNT_W-1:0] wait_last(input logic rs, input logic [7:0] data);
    return (!rs && (data == 8'h01 || data == 8'h02)) ? CLR_LAST : CMD_LAST;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             send_q, send_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
`ifdef LCD_AUTOWRAP_EN
  logic             line_q, line_d;            // current display line
  logic [4:0]       col_q, col_d;              // next column to be written, 0..16
  logic             pend_q, pend_d;            // data byte deferred behind a wrap command
  logic [7:0]       pend_data_q, pend_data_d;
`endif

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    // NOTE: every *_d is defaulted before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    done_d  = done_q;
    send_d  = 1'b0;
    rs_d    = rs_q;
    data_d  = data_q;
`ifdef LCD_AUTOWRAP_EN
    line_d      = line_q;
    col_d       = col_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
`endif

    case (state_q)
      PWR_WAIT: begin
        // Counts up from the reset value of 0; the only wait entered from reset.
        if (cnt_q == PWR_LAST) begin
          state_d = INIT_SEND;
          send_d  = 1'b1;
          rs_d    = 1'b0;
          data_d  = init_rom(idx_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      INIT_SEND: begin
        state_d = INIT_WAIT;
        cnt_d   = wait_last(rs_q, data_q);
`ifdef LCD_AUTOWRAP_EN
        if (data_q == 8'h01) begin
          line_d = 1'b0;
          col_d  = 5'd0;
        end
`endif
      end

      INIT_WAIT: begin
        if (cnt_q == '0) begin
          if (idx_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = INIT_SEND;
            send_d  = 1'b1;
            rs_d    = 1'b0;
            data_d  = init_rom(idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      IDLE: begin
        if (bus.req_valid && ready_q) begin
          state_d = SEND;
          ready_d = 1'b0;
          send_d  = 1'b1;
          rs_d    = bus.req_rs;
          data_d  = bus.req_data;
`ifdef LCD_AUTOWRAP_EN
          if (bus.req_rs) begin
            if (col_q == 5'd16) begin
              // Line full: move to the other line first, hold the data byte back.
              rs_d        = 1'b0;
              data_d      = line_q ? 8'h80 : 8'hC0;
              pend_d      = 1'b1;
              pend_data_d = bus.req_data;
              line_d      = ~line_q;
              col_d       = 5'd1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end else if (bus.req_data == 8'h01 || bus.req_data == 8'h02) begin
            line_d = 1'b0;
            col_d  = 5'd0;
          end else if (bus.req_data[7]) begin
            // A 4-bit address nibble is already within 0..15.
            line_d = bus.req_data[6];
            col_d  = {1'b0, bus.req_data[3:0]};
          end
`endif
        end
      end

      SEND: begin
        state_d = WAIT;
        cnt_d   = wait_last(rs_q, data_q);
      end

      WAIT: begin
        if (cnt_q == '0) begin
`ifdef LCD_AUTOWRAP_EN
          if (pend_q) begin
            state_d = SEND;
            send_d  = 1'b1;
            rs_d    = 1'b1;
            data_d  = pend_data_q;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
`else
          state_d = IDLE;
          ready_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = PWR_WAIT;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      send_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
`ifdef LCD_AUTOWRAP_EN
      line_q      <= 1'b0;
      col_q       <= 5'd0;
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      send_q  <= send_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
`ifdef LCD_AUTOWRAP_EN
      line_q      <= line_d;
      col_q       <= col_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign init_done     = done_q;
  assign lcd_send      = send_q;
  assign lcd_rs_sel    = rs_q;
  assign lcd_cmd_data  = data_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: self-checking bench for lcd_sequencer with short delays.
// Expected strobe times are derived arithmetically from acceptance cycles and
// the per-byte delay rules; the DUT is only observed, never consulted.
module tb_lcd_sequencer;
  localparam int PWR = 100;
  localparam int CMD = 30;
  localparam int CLR = 60;

  typedef struct {
    int         t;
    logic       rs;
    logic [7:0] d;
  } strobe_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done;
  logic       lcd_send;
  logic       lcd_rs_sel;
  logic [7:0] lcd_cmd_data;

  lcd_sequencer_if bus ();

  lcd_sequencer #(
    .PWR_DLY(PWR),
    .CMD_DLY(CMD),
    .CLR_DLY(CLR),
    .CNT_W  (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .init_done   (init_done),
    .lcd_send    (lcd_send),
    .lcd_rs_sel  (lcd_rs_sel),
    .lcd_cmd_data(lcd_cmd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  strobe_t seen[$];
  strobe_t exp_q[$];
  int      errors = 0;
  int      checks = 0;
  int      rr;  // model: cycle in which req_ready is next expected high
`ifdef LCD_AUTOWRAP_EN
  logic    m_line;
  int      m_col;
`endif

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) if (lcd_send === 1'b1) seen.push_back('{cyc, lcd_rs_sel, lcd_cmd_data});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_init(input int i);
    case (i)
      0:       return 8'h38;
      1:       return 8'h0C;
      2:       return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic int delay_of(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CLR : CMD;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_send"}, lcd_send, 1'b0);
    check({tag, "_rs"}, lcd_rs_sel, 1'b0);
    check({tag, "_data"}, lcd_cmd_data, 8'h00);
    check({tag, "_ready"}, bus.req_ready, 1'b0);
    check({tag, "_done"}, init_done, 1'b0);
  endtask

  // Releases reset and checks the complete init schedule up to req_ready.
  task automatic run_init(output int rr_out);
    int t0, t, tr, n;
    logic prev_done;
    @(negedge clk);
    rst = 1'b0;
    seen.delete();
    t0 = cyc;
    tr = -1;
    prev_done = init_done;
    for (int w = 0; w < 1000; w++) begin
      if (bus.req_ready === 1'b1) begin
        tr = cyc;
        break;
      end
      prev_done = init_done;
      @(negedge clk);
    end
    n = seen.size();
    check("init_strobe_count", n, 4);
    t = PWR;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        check($sformatf("init_time[%0d]", i), seen[i].t - t0, t);
        check($sformatf("init_rs[%0d]", i), seen[i].rs, 1'b0);
        check($sformatf("init_data[%0d]", i), seen[i].d, exp_init(i));
      end
      t += 1 + delay_of(1'b0, exp_init(i));
    end
    check("init_ready_cycle", tr - t0, t);
    check("init_done_before", prev_done, 1'b0);
    check("init_done_after", init_done, 1'b1);
    seen.delete();
    exp_q.delete();
`ifdef LCD_AUTOWRAP_EN
    m_line = 1'b0;
    m_col  = 0;
`endif
    rr_out = tr;
  endtask

  // Reference: strobes and ready-rise produced by one accepted byte.
  task automatic model(input int acc, input logic rs, input logic [7:0] d);
    int t = acc + 1;
`ifdef LCD_AUTOWRAP_EN
    if (rs && m_col == 16) begin
      exp_q.push_back('{t, 1'b0, m_line ? 8'h80 : 8'hC0});
      t += 1 + CMD;
      m_line = !m_line;
      m_col  = 1;
    end else if (rs) begin
      m_col++;
    end else if (d == 8'h01 || d == 8'h02) begin
      m_line = 1'b0;
      m_col  = 0;
    end else if (d[7]) begin
      m_line = d[6];
      m_col  = (d[3:0] > 15) ? 15 : int'(d[3:0]);
    end
`endif
    exp_q.push_back('{t, rs, d});
    rr = t + 1 + delay_of(rs, d);
  endtask

  // Byte i of the traffic: 0x41 first, 16 more data bytes, a clear, then random.
  task automatic gen_byte(input int i, output logic rs, output logic [7:0] d);
    int k;
    if (i < 17) begin
      rs = 1'b1;
      d  = 8'(32 + $urandom_range(0, 94));
    end else if (i == 17) begin
      rs = 1'b0;
      d  = 8'h01;
    end else begin
      k = $urandom_range(0, 9);
      rs = (k <= 5);
      case (k)
        6:       d = 8'h01;
        7:       d = 8'h02;
        8:       d = 8'h80 | 8'($urandom_range(0, 127));
        9:       d = 8'($urandom_range(3, 127));
        default: d = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Drives n bytes (the first already presented at cycle p_in) and checks acceptance timing.
  task automatic traffic(input int n, input int p_in);
    int p, acc;
    logic rs;
    logic [7:0] d;
    p = p_in;
    for (int i = 0; i < n; i++) begin
      rs  = bus.req_rs;
      d   = bus.req_data;
      acc = -1;
      for (int w = 0; w < 500; w++) begin
        if (bus.req_ready === 1'b1) begin
          acc = cyc;
          break;
        end
        @(negedge clk);
      end
      check($sformatf("accept_cycle[%0d]", i), acc, (p > rr) ? p : rr);
      if (acc < 0) break;
      model(acc, rs, d);
      @(negedge clk);
      check($sformatf("ready_drop[%0d]", i), bus.req_ready, 1'b0);
      if (i == n - 1) begin
        bus.req_valid = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          bus.req_valid = 1'b0;
          repeat ($urandom_range(1, 50)) @(negedge clk);
        end
        gen_byte(i + 1, rs, d);
        bus.req_rs    = rs;
        bus.req_data  = d;
        bus.req_valid = 1'b1;
        p = cyc;
      end
    end
  endtask

  initial begin
    int p, n, dbl, t0;
    bus.req_valid = 1'b0;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // Byte held valid throughout init: must wait for req_ready.
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h41;
    p = cyc;
    run_init(rr);

    traffic(60, p);
    for (int w = 0; w < 2000 && cyc < rr + 3; w++) @(negedge clk);
    n = (seen.size() < exp_q.size()) ? seen.size() : exp_q.size();
    check("strobe_count", seen.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      check($sformatf("strobe_time[%0d]", i), seen[i].t, exp_q[i].t);
      check($sformatf("strobe_rs[%0d]", i), seen[i].rs, exp_q[i].rs);
      check($sformatf("strobe_data[%0d]", i), seen[i].d, exp_q[i].d);
    end
    dbl = 0;
    for (int i = 1; i < seen.size(); i++) if (seen[i].t - seen[i-1].t < 2) dbl++;
    check("no_double_strobe", dbl, 0);

    // Reset in the middle of a return-home wait.
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h02;
    bus.req_valid = 1'b1;
    for (int w = 0; w < 200 && bus.req_ready !== 1'b1; w++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midwait_reset");
    repeat (2) @(negedge clk);

    // Reset during the wait after 0x0C, then a full restart.
    @(negedge clk);
    rst = 1'b0;
    seen.delete();
    t0 = cyc;
    repeat (140) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("initwait_reset");
    check("partial_init_count", seen.size(), 2);
    if (seen.size() >= 2) begin
      check("partial_0c_time", seen[1].t - t0, PWR + 1 + CMD);
      check("partial_0c_data", seen[1].d, 8'h0C);
    end
    repeat (2) @(negedge clk);
    run_init(rr);
    repeat (20) @(negedge clk);
    check("idle_quiet", seen.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
